shift_datapath_seq: RTL and testbench
=====================================

Name: shift_datapath_seq

Overview:
Parametrised successor to the 8-bit mux/shift/register datapath. It loads an operand chosen from two sources into a WIDTH-bit working register. It then applies a programmable shift or rotate a programmed number of times under a start/busy/done handshake. Its consumer is the LED/pattern logic downstream of the PLL clock domain.

Parameters:
WIDTH, 8, datapath width in bits (>= 2)
CNT_W, 4, width of step-count field; max steps = 2^CNT_W - 1
SHW (localparam), $clog2(WIDTH), width of shift-amount field

Ports:
clk_in  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only in IDLE or DONE
sel_src  input  1  operand select: 0 = a, 1 = b
a  input  WIDTH  operand source 0
b  input  WIDTH  operand source 1
mode  input  3  operation code, latched at start
shamt  input  SHW  bits moved per step, latched at start
steps  input  CNT_W  number of steps, latched at start
clr  input  1  synchronous clear/abort
out  output  WIDTH  working register contents (registered)
busy  output  1  high while in RUN
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, out=0, busy=0, done=0, internal count/mode/shamt=0.
- States: IDLE, RUN, DONE. busy=1 iff RUN; done=1 iff DONE. Both are registered state decodes.
- IDLE/DONE with start=1 at an edge:
  - out <= (sel_src ? b : a).
  - Latch mode, shamt, steps.
  - Next state is RUN if steps!=0, else DONE.
- IDLE/DONE with start=0: DONE -> IDLE, IDLE stays. out holds.
- RUN: each edge applies one op to out and decrements the count. The edge applying the final op moves to DONE. With steps=N, done is high exactly N cycles after the load edge; with steps=0, 1 cycle after.
- start is ignored while in RUN. Back-to-back: start sampled in DONE launches the next op with no IDLE cycle.
- mode encoding (k = latched shamt):
  - 000 hold
  - 001 logical right
  - 010 logical left
  - 011 rotate right
  - 100 rotate left
  - 101 arithmetic right (MSB fill)
  - 110/111 hold (reserved)
- k=0: every mode is hold, but steps still count and done still fires.
- Non-power-of-2 WIDTH:
  - k >= WIDTH gives 0 for logical shifts and all-MSB for arithmetic right.
  - Rotates use k mod WIDTH.
- Inputs a, b, mode, shamt and steps may change freely after the load edge without affecting the operation in flight.
- clr=1 at an edge (any state, priority over start):
  - out <= 0, state <= IDLE, count <= 0.
  - No done pulse.
  - A start in the same cycle is dropped.
- rst_n asserted mid-RUN: immediate return to reset values. No done pulse after release.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out=8'h00, busy=0, done=0. Deassert, idle 3 cycles -> unchanged.
- a=8'h80, sel_src=0, mode=001, shamt=1, steps=3, pulse start:
  - out sequence 80,40,20,10.
  - busy high 3 cycles, then done=1 for one cycle with out=8'h10.
- Rotates, b=8'h01, sel_src=1, mode=100, shamt=1, steps=8 -> out returns to 8'h01, done after 8 cycles.
- a=8'h81, mode=011, shamt=3, steps=1 -> out=8'h30.
- Arithmetic/left, a=8'h90, mode=101, shamt=2, steps=1 -> out=8'hE4.
- Arithmetic/left, a=8'h03, mode=010, shamt=7, steps=1 -> 8'h80.
- Abort: a=8'h01, mode=010, shamt=1, steps=5; start again after 1 op (ignored); clr after 2 ops (out=8'h04) -> next cycle out=8'h00, busy=0, done never pulses.
- Edge cases:
  - steps=0, a=8'h5A -> out=8'h5A, done one cycle later.
  - start held high through DONE -> immediate relaunch.
  - rst_n pulsed mid-RUN -> out=0 asynchronously, no done.

Source files
------------

// File: rtl/shift_datapath_seq.sv
// Parametrised load/shift/rotate datapath with a start/busy/done handshake.
// An operand is loaded from a or b, then a latched op is applied a latched number of times.
module shift_datapath_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sel_src,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [CNT_W-1:0] steps,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] out_q, out_next;
  logic [CNT_W-1:0] count, count_next;
  logic [2:0]       mode_q, mode_next;
  logic [SHW-1:0]   shamt_q, shamt_next;

  // One step of the latched operation; rotates wrap the amount modulo WIDTH
  // so non-power-of-2 widths behave, and k = 0 degenerates to hold.
  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] v,
                                                input logic [2:0]       m,
                                                input logic [SHW-1:0]   k);
    logic [WIDTH-1:0] r;
    int unsigned      rot;
    rot = 32'(k) % WIDTH;
    case (m)
      3'b001:  r = v >> k;
      3'b010:  r = v << k;
      3'b011:  r = (v >> rot) | (v << (WIDTH - rot));
      3'b100:  r = (v << rot) | (v >> (WIDTH - rot));
      3'b101:  r = WIDTH'($signed(v) >>> k);
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_q   <= '0;
      count   <= '0;
      mode_q  <= '0;
      shamt_q <= '0;
    end else begin
      state   <= state_next;
      out_q   <= out_next;
      count   <= count_next;
      mode_q  <= mode_next;
      shamt_q <= shamt_next;
    end
  end

  // clr outranks everything, so a start in the same cycle is simply lost.
  always_comb begin
    state_next = state;
    out_next   = out_q;
    count_next = count;
    mode_next  = mode_q;
    shamt_next = shamt_q;
    if (clr) begin
      state_next = IDLE;
      out_next   = '0;
      count_next = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            out_next   = sel_src ? b : a;
            mode_next  = mode;
            shamt_next = shamt;
            count_next = steps;
            state_next = (steps != '0) ? RUN : DONE;
          end else begin
            state_next = IDLE;
          end
        end
        RUN: begin
          out_next   = apply_op(out_q, mode_q, shamt_q);
          count_next = count - CNT_W'(1);
          if (count == CNT_W'(1)) state_next = DONE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_datapath_seq.sv
// Self-checking bench for shift_datapath_seq: table vectors, random ops against
// a bit-level reference model, and hand-written abort/relaunch/reset sequences.
module tb_shift_datapath_seq;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sel_src;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   mode;
  logic [2:0]   shamt;
  logic [3:0]   steps;
  logic         clr;
  logic [W-1:0] out;
  logic         busy;
  logic         done;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic         sel;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [2:0]   m;
    logic [2:0]   k;
    logic [3:0]   n;
    logic [W-1:0] expect_out;
  } vec_t;

  vec_t vecs[9];

  shift_datapath_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .start  (start),
    .sel_src(sel_src),
    .a      (a),
    .b      (b),
    .mode   (mode),
    .shamt  (shamt),
    .steps  (steps),
    .clr    (clr),
    .out    (out),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each result bit is picked from its source bit position.
  function automatic logic [W-1:0] ref_step(input logic [W-1:0] v, input int m, input int k);
    logic [W-1:0] r;
    r = v;
    if (k == 0 || m == 0 || m > 5) return v;
    for (int i = 0; i < W; i++) begin
      case (m)
        1: r[i] = (i + k < W) ? v[i + k] : 1'b0;
        2: r[i] = (i - k >= 0) ? v[i - k] : 1'b0;
        3: r[i] = v[(i + k) % W];
        4: r[i] = v[(i - (k % W) + W) % W];
        5: r[i] = (i + k < W) ? v[i + k] : v[W-1];
        default: r[i] = v[i];
      endcase
    end
    return r;
  endfunction

  task automatic scramble_inputs();
    a       = W'($urandom);
    b       = W'($urandom);
    mode    = 3'($urandom);
    shamt   = 3'($urandom);
    steps   = 4'($urandom);
    sel_src = 1'($urandom);
  endtask

  // Launches one op, checks every cycle against the model, returns to IDLE.
  task automatic apply_stimulus(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic [2:0] m, input logic [2:0] k, input logic [3:0] n,
                                output logic [W-1:0] final_out);
    logic [W-1:0] exp_v;
    sel_src = s; a = va; b = vb; mode = m; shamt = k; steps = n;
    start = 1'b1;
    exp_v = s ? vb : va;
    tick();
    start = 1'b0;
    scramble_inputs();
    check_output("load_out", 32'(out), 32'(exp_v));
    check_output("load_busy", 32'(busy), 32'(n != 0));
    check_output("load_done", 32'(done), 32'(n == 0));
    for (int i = 1; i <= int'(n); i++) begin
      tick();
      exp_v = ref_step(exp_v, int'(m), int'(k));
      check_output("step_out", 32'(out), 32'(exp_v));
      check_output("step_done", 32'(done), 32'(i == int'(n)));
      check_output("step_busy", 32'(busy), 32'(i != int'(n)));
    end
    final_out = out;
    tick();
    check_output("idle_done", 32'(done), 32'(0));
    check_output("idle_busy", 32'(busy), 32'(0));
    check_output("idle_hold", 32'(out), 32'(exp_v));
  endtask

  initial begin
    logic [W-1:0] res;
    vecs[0] = '{1'b0, 8'h80, 8'hFF, 3'b001, 3'd1, 4'd3, 8'h10};
    vecs[1] = '{1'b1, 8'hAA, 8'h01, 3'b100, 3'd1, 4'd8, 8'h01};
    vecs[2] = '{1'b0, 8'h81, 8'h00, 3'b011, 3'd3, 4'd1, 8'h30};
    vecs[3] = '{1'b0, 8'h90, 8'h00, 3'b101, 3'd2, 4'd1, 8'hE4};
    vecs[4] = '{1'b0, 8'h03, 8'h00, 3'b010, 3'd7, 4'd1, 8'h80};
    vecs[5] = '{1'b0, 8'h5A, 8'h00, 3'b001, 3'd1, 4'd0, 8'h5A};
    vecs[6] = '{1'b1, 8'h00, 8'hC3, 3'b110, 3'd3, 4'd2, 8'hC3};
    vecs[7] = '{1'b0, 8'hF0, 8'h00, 3'b001, 3'd0, 4'd3, 8'hF0};
    vecs[8] = '{1'b0, 8'h96, 8'h00, 3'b101, 3'd1, 4'd15, 8'hFF};

    rst_n = 1'b0; clr = 1'b0; start = 1'b1;
    scramble_inputs();
    repeat (3) begin
      tick();
      scramble_inputs();
    end
    check_output("rst_out", 32'(out), 32'(0));
    check_output("rst_busy", 32'(busy), 32'(0));
    check_output("rst_done", 32'(done), 32'(0));
    start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) tick();
    check_output("post_rst_out", 32'(out), 32'(0));
    check_output("post_rst_busy", 32'(busy), 32'(0));
    check_output("post_rst_done", 32'(done), 32'(0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].sel, vecs[i].va, vecs[i].vb, vecs[i].m, vecs[i].k, vecs[i].n, res);
      check_output($sformatf("vec%0d_final", i), 32'(res), 32'(vecs[i].expect_out));
    end

    for (int i = 0; i < 40; i++) begin
      apply_stimulus(1'($urandom), W'($urandom), W'($urandom), 3'($urandom),
                     3'($urandom), 4'($urandom_range(0, 15)), res);
    end

    // Abort: start ignored mid-run, clr after two ops, no done afterwards.
    sel_src = 1'b0; a = 8'h01; mode = 3'b010; shamt = 3'd1; steps = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("abort_op1", 32'(out), 32'(8'h02));
    start = 1'b1; a = 8'hEE;
    tick();
    start = 1'b0;
    check_output("abort_op2", 32'(out), 32'(8'h04));
    check_output("abort_busy", 32'(busy), 32'(1));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_output("abort_out", 32'(out), 32'(0));
    check_output("abort_busy_clr", 32'(busy), 32'(0));
    for (int i = 0; i < 8; i++) begin
      check_output("abort_no_done", 32'(done), 32'(0));
      tick();
    end

    // clr in the same cycle as start drops the start.
    a = 8'h77; steps = 4'd2; start = 1'b1; clr = 1'b1;
    tick();
    start = 1'b0; clr = 1'b0;
    check_output("clr_start_out", 32'(out), 32'(0));
    check_output("clr_start_busy", 32'(busy), 32'(0));

    // start held high through DONE relaunches with no IDLE cycle.
    sel_src = 1'b0; a = 8'h5A; mode = 3'b000; shamt = 3'd2; steps = 4'd2;
    start = 1'b1;
    tick();
    a = 8'h3C; mode = 3'b001; shamt = 3'd1; steps = 4'd1;
    tick();
    tick();
    check_output("b2b_done1", 32'(done), 32'(1));
    check_output("b2b_out1", 32'(out), 32'(8'h5A));
    tick();
    start = 1'b0;
    check_output("b2b_reload", 32'(out), 32'(8'h3C));
    check_output("b2b_busy", 32'(busy), 32'(1));
    tick();
    check_output("b2b_done2", 32'(done), 32'(1));
    check_output("b2b_out2", 32'(out), 32'(8'h1E));
    tick();

    // Asynchronous reset mid-run.
    a = 8'hFF; mode = 3'b001; shamt = 3'd1; steps = 4'd10; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check_output("arst_pre_out", 32'(out), 32'(8'h3F));
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_out", 32'(out), 32'(0));
    check_output("arst_busy", 32'(busy), 32'(0));
    check_output("arst_done", 32'(done), 32'(0));
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_output("arst_no_done", 32'(done), 32'(0));
    end
    check_output("arst_idle_out", 32'(out), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
